// File: rtl/hyperram_arb_pkg.sv
// Shared state type and round-robin select function for the HyperRAM request arbiter.
// The function walks at most MaxPorts requesters, which is the widest arbiter supported.
package hyperram_arb_pkg;

    localparam int MaxPorts = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2
    } arb_state_e;

    function automatic logic [MaxPorts-1:0] rr_pick(input logic [MaxPorts-1:0] req,
                                                    input logic [2:0]          ptr,
                                                    input int                  ports);
        logic [MaxPorts-1:0] pick;
        logic [3:0]          idx;
        pick = '0;
        // Walk downward so the requester closest above the pointer is written last and wins.
        for (int k = MaxPorts - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(ports)) begin
                idx = idx - 4'(ports);
            end
            if ((k < ports) && req[idx[2:0]]) begin
                pick            = '0;
                pick[idx[2:0]]  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hyperram_rr_picker.sv
// Combinational requester select: round-robin upward from ptr with wrap modulo Ports.
// With HYPERRAM_ARB_FIXED_PRIO_EN defined, port 0 wins whenever it is requesting.
module hyperram_rr_picker
    import hyperram_arb_pkg::*;
#(
    parameter  int Ports = 2,
    localparam int PtrW  = $clog2(Ports)
) (
    input  logic [Ports-1:0] req,
    input  logic [PtrW-1:0]  ptr,
    output logic [Ports-1:0] pick
);

    logic [MaxPorts-1:0] req_ext;
    logic [MaxPorts-1:0] pick_ext;
    logic                unused_pick_hi;

    always_comb begin
        req_ext             = '0;
        req_ext[Ports-1:0]  = req;
`ifdef HYPERRAM_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            pick_ext    = '0;
            pick_ext[0] = 1'b1;
        end else begin
            pick_ext = rr_pick(req_ext, 3'(ptr), Ports);
        end
`else
        pick_ext = rr_pick(req_ext, 3'(ptr), Ports);
`endif
    end

    assign pick           = pick_ext[Ports-1:0];
    assign unused_pick_hi = ^pick_ext;

endmodule

// File: rtl/hyperram_request_arbiter.sv
// Shares one RetroHyperRAM controller among Ports requesters, one whole burst per grant.
// Optional build macro: HYPERRAM_ARB_FIXED_PRIO_EN (port 0 wins whenever it requests).
//
//  state  | meaning
//  IDLE   | no burst; arbitrate and latch the winner's command
//  ISSUE  | TgtReq high with latched command, waiting for TgtAck
//  ACTIVE | burst running; beats and completion routed to the granted port
module hyperram_request_arbiter
    import hyperram_arb_pkg::*;
#(
    parameter int Ports           = 2,
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8,
    parameter int BurstWidth      = 7
) (
    input  logic                                      Clk,
    input  logic                                      nReset,
    input  logic [Ports-1:0]                          Req,
    input  logic [Ports-1:0]                          Write,
    input  logic [Ports-1:0][AddressBusWidth-1:0]     Address,
    input  logic [Ports-1:0][BurstWidth-1:0]          BurstLen,
    input  logic [Ports-1:0][DataBusWidth-1:0]        WData,
    output logic [Ports-1:0]                          Ack,
    output logic [Ports-1:0]                          WTake,
    output logic [Ports-1:0]                          RValid,
    output logic [DataBusWidth-1:0]                   RData,
    output logic [Ports-1:0]                          Done,
    output logic                                      TgtReq,
    output logic                                      TgtWrite,
    output logic [AddressBusWidth-1:0]                TgtAddress,
    output logic [BurstWidth-1:0]                     TgtBurstLen,
    input  logic                                      TgtAck,
    output logic [DataBusWidth-1:0]                   TgtWData,
    input  logic                                      TgtWTake,
    input  logic                                      TgtRValid,
    input  logic [DataBusWidth-1:0]                   TgtRData,
    input  logic                                      TgtDone
);

    localparam int PtrW = $clog2(Ports);

    arb_state_e      state, state_nxt;
    logic [PtrW-1:0] grant, rr_ptr, win_idx;
    logic [Ports-1:0] pick;
    logic            done_pend, load, set_pend, finish;

    hyperram_rr_picker #(.Ports(Ports)) u_picker (
        .req  (Req),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < Ports; i++) begin
            if (pick[i]) win_idx = PtrW'(i);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            done_pend   <= 1'b0;
            TgtWrite    <= 1'b0;
            TgtAddress  <= '0;
            TgtBurstLen <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                grant       <= win_idx;
                TgtWrite    <= Write[win_idx];
                TgtAddress  <= Address[win_idx];
                TgtBurstLen <= BurstLen[win_idx];
            end
            if (set_pend) begin
                done_pend <= 1'b1;
            end else if (finish) begin
                done_pend <= 1'b0;
            end
            if (finish) begin
                rr_ptr <= (grant == PtrW'(Ports - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        set_pend  = 1'b0;
        finish    = 1'b0;
        TgtReq    = 1'b0;
        TgtWData  = '0;
        RData     = '0;
        Ack       = '0;
        WTake     = '0;
        RValid    = '0;
        Done      = '0;
        unique case (state)
            IDLE: begin
                if (|Req) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                TgtReq = 1'b1;
                if (TgtAck) begin
                    Ack[grant] = 1'b1;
                    // A zero-length target may finish with the accept; report Done one cycle later.
                    set_pend   = TgtDone;
                    state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                TgtWData      = WData[grant];
                WTake[grant]  = TgtWTake;
                RValid[grant] = TgtRValid;
                if (TgtRValid) RData = TgtRData;
                if (TgtDone || done_pend) begin
                    Done[grant] = 1'b1;
                    finish      = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requesters hold Req until their Ack; the latched command relies on it.
    a_req_held: assert property (@(posedge Clk) disable iff (!nReset)
                                 (state == ISSUE) |-> Req[grant]);

endmodule

// File: tb/tb_hyperram_request_arbiter.sv
// Scoreboard bench for hyperram_request_arbiter: directed bursts push expected commands,
// read beats and completions; negedge monitors pop and compare whenever the DUT responds.
module tb_hyperram_request_arbiter;

    logic              Clk = 1'b0;
    logic              nReset;
    logic [1:0]        Req, Write, Ack, WTake, RValid, Done;
    logic [1:0][15:0]  Address;
    logic [1:0][6:0]   BurstLen;
    logic [1:0][7:0]   WData;
    logic [7:0]        RData, TgtWData, TgtRData;
    logic              TgtReq, TgtWrite, TgtAck, TgtWTake, TgtRValid, TgtDone;
    logic [15:0]       TgtAddress;
    logic [6:0]        TgtBurstLen;

    logic [2:0]        Req3, Write3, Ack3, WTake3, RValid3, Done3;
    logic [2:0][15:0]  Address3;
    logic [2:0][6:0]   BurstLen3;
    logic [2:0][7:0]   WData3;
    logic [7:0]        RData3, TgtWData3, TgtRData3;
    logic              TgtReq3, TgtWrite3, TgtAck3, TgtWTake3, TgtRValid3, TgtDone3;
    logic [15:0]       TgtAddress3;
    logic [6:0]        TgtBurstLen3;

    typedef struct {int port; logic wr; logic [15:0] addr; logic [6:0] len;} cmd_t;
    typedef struct {int port; logic [7:0] data;} rd_t;

    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];
    int   exp_done[$];
    int   exp_ack3[$];

    int   checks = 0, errors = 0;
    int   cur_port = 0, wtake_cnt = 0, lat;
    cmd_t mc;
    rd_t  mr;
    int   md;

    always #5 Clk = ~Clk;

    hyperram_request_arbiter #(.Ports(2), .AddressBusWidth(16), .DataBusWidth(8), .BurstWidth(7)) u_dut (
        .Clk(Clk), .nReset(nReset), .Req(Req), .Write(Write), .Address(Address),
        .BurstLen(BurstLen), .WData(WData), .Ack(Ack), .WTake(WTake), .RValid(RValid),
        .RData(RData), .Done(Done), .TgtReq(TgtReq), .TgtWrite(TgtWrite),
        .TgtAddress(TgtAddress), .TgtBurstLen(TgtBurstLen), .TgtAck(TgtAck),
        .TgtWData(TgtWData), .TgtWTake(TgtWTake), .TgtRValid(TgtRValid),
        .TgtRData(TgtRData), .TgtDone(TgtDone)
    );

    hyperram_request_arbiter #(.Ports(3), .AddressBusWidth(16), .DataBusWidth(8), .BurstWidth(7)) u_dut3 (
        .Clk(Clk), .nReset(nReset), .Req(Req3), .Write(Write3), .Address(Address3),
        .BurstLen(BurstLen3), .WData(WData3), .Ack(Ack3), .WTake(WTake3), .RValid(RValid3),
        .RData(RData3), .Done(Done3), .TgtReq(TgtReq3), .TgtWrite(TgtWrite3),
        .TgtAddress(TgtAddress3), .TgtBurstLen(TgtBurstLen3), .TgtAck(TgtAck3),
        .TgtWData(TgtWData3), .TgtWTake(TgtWTake3), .TgtRValid(TgtRValid3),
        .TgtRData(TgtRData3), .TgtDone(TgtDone3)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Main DUT monitor: commands, read beats, write beats, completions.
    always @(negedge Clk) begin
        if (|Ack) begin
            if (exp_cmd.size() == 0) begin
                chk("unexpected_ack", 32'(Ack), 32'd0);
            end else begin
                mc       = exp_cmd.pop_front();
                cur_port = mc.port;
                chk("ack_port", 32'(Ack), 32'(1 << mc.port));
                chk("tgt_req_at_ack", 32'(TgtReq), 32'd1);
                chk("tgt_addr", 32'(TgtAddress), 32'(mc.addr));
                chk("tgt_len", 32'(TgtBurstLen), 32'(mc.len));
                chk("tgt_write", 32'(TgtWrite), 32'(mc.wr));
            end
        end
        if (|RValid) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_rvalid", 32'(RValid), 32'd0);
            end else begin
                mr = exp_rd.pop_front();
                chk("rvalid_port", 32'(RValid), 32'(1 << mr.port));
                chk("rdata", 32'(RData), 32'(mr.data));
            end
        end
        if (TgtWTake || (|WTake)) begin
            chk("wtake_port", 32'(WTake), TgtWTake ? 32'(1 << cur_port) : 32'd0);
            chk("tgt_wdata", 32'(TgtWData), 32'(WData[cur_port]));
            if (|WTake) wtake_cnt++;
        end
        if (|Done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                md = exp_done.pop_front();
                chk("done_port", 32'(Done), 32'(1 << md));
            end
        end
    end

    always @(negedge Clk) begin
        if (|Ack3) begin
            if (exp_ack3.size() == 0) begin
                chk("unexpected_ack3", 32'(Ack3), 32'd0);
            end else begin
                chk("ack3_port", 32'(Ack3), 32'(1 << exp_ack3.pop_front()));
            end
        end
    end

    // Acts as the controller for one burst whose expected winner is p.
    task automatic serve(input int p, input int nbeats, input bit zl, input bit drop_req,
                         output int wait_cycles);
        cmd_t c;
        c.port = p;
        c.wr   = Write[p];
        c.addr = Address[p];
        c.len  = BurstLen[p];
        exp_cmd.push_back(c);
        exp_done.push_back(p);
        wait_cycles = 0;
        while (!TgtReq && wait_cycles < 40) begin
            tick();
            wait_cycles++;
        end
        chk("tgt_req_seen", 32'(TgtReq), 32'd1);
        TgtAck  = 1'b1;
        TgtDone = zl;
        if (zl) begin
            #1;
            chk("done_not_with_ack", 32'(Done), 32'd0);
        end
        tick();
        TgtAck  = 1'b0;
        TgtDone = 1'b0;
        if (drop_req) Req[p] = 1'b0;
        if (zl) chk("done_after_ack", 32'(Done), 32'(1 << p));
        for (int i = 0; i < nbeats; i++) begin
            if (Write[p]) begin
                TgtWTake = 1'b1;
            end else begin
                TgtRValid = 1'b1;
                TgtRData  = 8'(8'h40 + 16 * p + i);
                exp_rd.push_back(rd_t'{p, TgtRData});
            end
            tick();
            if (Write[p]) WData[p] = WData[p] + 8'd1;
            TgtWTake  = 1'b0;
            TgtRValid = 1'b0;
        end
        if (!zl) begin
            TgtDone = 1'b1;
            tick();
            TgtDone = 1'b0;
        end else begin
            tick();
        end
    endtask

    task automatic serve3(input int p);
        int n = 0;
        exp_ack3.push_back(p);
        while (!TgtReq3 && n < 40) begin
            tick();
            n++;
        end
        chk("tgt_req3_seen", 32'(TgtReq3), 32'd1);
        TgtAck3 = 1'b1;
        tick();
        TgtAck3 = 1'b0;
        Req3[p] = 1'b0;
        TgtDone3 = 1'b1;
        tick();
        TgtDone3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nReset = 1'b0;
        Req = '0; Write = '0; Address = '0; BurstLen = '0; WData = '0;
        TgtAck = 1'b0; TgtWTake = 1'b0; TgtRValid = 1'b0; TgtRData = '0; TgtDone = 1'b0;
        Req3 = '0; Write3 = '0; Address3 = '0; BurstLen3 = '0; WData3 = '0;
        TgtAck3 = 1'b0; TgtWTake3 = 1'b0; TgtRValid3 = 1'b0; TgtRData3 = '0; TgtDone3 = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst_tgt_req", 32'(TgtReq), 32'd0);
        chk("rst_tgt_addr", 32'(TgtAddress), 32'd0);
        chk("rst_tgt_len", 32'(TgtBurstLen), 32'd0);
        chk("rst_tgt_write", 32'(TgtWrite), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        nReset = 1'b1;
        tick();

        // Single read on port 1
        Address[1] = 16'h1234; BurstLen[1] = 7'd3; Write[1] = 1'b0; Req[1] = 1'b1;
        serve(1, 4, 1'b0, 1'b1, lat);
        chk("issue_latency", 32'(lat), 32'd1);

        // 128-beat write on port 0
        Address[0] = 16'h4000; BurstLen[0] = 7'd127; Write[0] = 1'b1; WData[0] = 8'h10;
        wtake_cnt = 0; Req[0] = 1'b1;
        serve(0, 128, 1'b0, 1'b1, lat);
        chk("wtake_count", 32'(wtake_cnt), 32'd128);

        // Zero-length target: Ack and Done in the same controller cycle
        Address[1] = 16'h0ABC; BurstLen[1] = 7'd0; Write[1] = 1'b0; Req[1] = 1'b1;
        serve(1, 0, 1'b1, 1'b1, lat);

        // Both ports held for six bursts
        Write = '0; Address[0] = 16'h0100; Address[1] = 16'h0200;
        BurstLen[0] = 7'd0; BurstLen[1] = 7'd1; Req = 2'b11;
        for (int b = 0; b < 6; b++) begin
`ifdef HYPERRAM_ARB_FIXED_PRIO_EN
            serve(0, 1, 1'b0, 1'b0, lat);
`else
            serve(b % 2, (b % 2) + 1, 1'b0, 1'b0, lat);
`endif
        end
        Req = '0;

        // Leave the pointer at 1, then reset mid-burst
        Address[0] = 16'h5555; BurstLen[0] = 7'd3; Req[0] = 1'b1;
        serve(0, 1, 1'b0, 1'b1, lat);
        Req[0] = 1'b1;
        exp_cmd.push_back(cmd_t'{0, 1'b0, 16'h5555, 7'd3});
        lat = 0;
        while (!TgtReq && lat < 40) begin
            tick();
            lat++;
        end
        chk("tgt_req_seen_rst", 32'(TgtReq), 32'd1);
        TgtAck = 1'b1;
        tick();
        TgtAck = 1'b0;
        Req[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            TgtRValid = 1'b1;
            TgtRData  = 8'(8'hC0 + i);
            exp_rd.push_back(rd_t'{0, TgtRData});
            tick();
            TgtRValid = 1'b0;
        end
        TgtRValid = 1'b1; TgtRData = 8'hEE;
        nReset = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(RValid), 32'd0);
        chk("midrst_rdata", 32'(RData), 32'd0);
        chk("midrst_tgt_req", 32'(TgtReq), 32'd0);
        chk("midrst_tgt_addr", 32'(TgtAddress), 32'd0);
        chk("midrst_tgt_len", 32'(TgtBurstLen), 32'd0);
        tick();
        TgtRValid = 1'b0; TgtDone = 1'b1;
        #1;
        chk("midrst_no_done", 32'(Done), 32'd0);
        tick();
        TgtDone = 1'b0; nReset = 1'b1;
        tick();
        TgtDone = 1'b1;
        #1;
        chk("postrst_no_done", 32'(Done), 32'd0);
        tick();
        TgtDone = 1'b0;
        tick();
        chk("postrst_idle", 32'(TgtReq), 32'd0);

        // Pointer must be back at 0 after reset: port 0 first, then port 1
        Address[0] = 16'h0300; Address[1] = 16'h0400; BurstLen = '0; Req = 2'b11;
        serve(0, 1, 1'b0, 1'b1, lat);
        serve(1, 1, 1'b0, 1'b1, lat);

        // Three ports: move pointer to 2, then wrap to port 0 and on to port 1
        Address3[0] = 16'h1000; Address3[1] = 16'h1100; Address3[2] = 16'h1200;
        Req3 = 3'b010;
        serve3(1);
        Req3 = 3'b011;
        serve3(0);
        serve3(1);

        tick();
        tick();
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        chk("ack3_queue_empty", 32'(exp_ack3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
